// File: rtl/rm_m8c7_pkg.sv
// Shared types and constants for the monitor-8 cluster-7 report collector.
// A record is the timestamp of the capturing run cycle followed by the raw report vector.
package rm_m8c7_pkg;

    localparam int REPORT_W     = 36;
    localparam int TS_W         = 32;
    localparam int AUTOMATON_W  = 4;
    localparam int NUM_AUTOMATA = 9;

    // Report vector follows stage-0 port order: ltl8 occupies the lowest nibble.
    localparam int LTL8_BASE = 0;
    localparam int LTL4_BASE = 32;

    typedef struct packed {
        logic [TS_W-1:0]     ts;
        logic [REPORT_W-1:0] reports;
    } record_t;

    typedef enum logic {
        ST_EMPTY    = 1'b0,
        ST_NONEMPTY = 1'b1
    } fifo_state_e;

    function automatic int report_base(input int automaton_idx);
        return automaton_idx * AUTOMATON_W;
    endfunction

endpackage

// File: rtl/rm_m8c7_report_collector_if.sv
// Host-side readout channel: the collector is master of valid/data, the host drives ready.
interface rm_m8c7_report_collector_if;
    import rm_m8c7_pkg::*;

    logic    out_valid;
    logic    out_ready;
    record_t out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/rm_sync_fifo.sv
// Synchronous FIFO with a registered head word; a write is visible at the head one cycle later.
// Occupancy comes from extra-bit pointers that wrap naturally.
module rm_sync_fifo
    import rm_m8c7_pkg::*;
#(
    parameter int WIDTH = 68,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    fifo_state_e      state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             valid;
    logic             pop;
    logic             wr_en;

    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == PW'(DEPTH));
    assign valid = (state_q == ST_NONEMPTY);
    assign empty = !valid;
    assign rdata = rdata_q;
    assign pop   = valid && out_ready;
    assign wr_en = push && (!full || pop);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case (state_q)
            ST_EMPTY: begin
                if (wr_en) begin
                    state_d = ST_NONEMPTY;
                end
            end
            ST_NONEMPTY: begin
                if (pop && !wr_en && (level == PW'(1))) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // The next head is forwarded from the write port when it lands in the slot about to be read.
    always_comb begin
        rdata_d = mem_q[rd_ptr_d[AW-1:0]];
        if (wr_en && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
            rdata_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: rtl/rm_m8c7_report_collector.sv
// Timestamps every run cycle with at least one report and queues it for the host.
// A full queue drops the record and counts it instead of back-pressuring the automata.
module rm_m8c7_report_collector
    import rm_m8c7_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic [REPORT_W-1:0]           reports,
    input  logic                          clear_ovf,
    rm_m8c7_report_collector_if.master    out_if,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          overflow,
    output logic [DROP_W-1:0]             drop_count
);

    logic [TS_W-1:0]   ts_q, ts_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
    logic              capture;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    record_t           capture_rec;
    logic [TS_W+REPORT_W-1:0] fifo_rdata;

    assign capture     = run && (|reports);
    assign capture_rec = '{ts: ts_q, reports: reports};
    assign pop         = !fifo_empty && out_if.out_ready;
    assign drop        = capture && fifo_full && !pop;

    rm_sync_fifo #(
        .WIDTH (TS_W + REPORT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (capture),
        .wdata     (capture_rec),
        .out_ready (out_if.out_ready),
        .rdata     (fifo_rdata),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = fifo_rdata;
    assign overflow         = overflow_q;
    assign drop_count       = drop_count_q;

    // A drop on the same edge as clear_ovf restarts the count at one rather than zero.
    always_comb begin
        ts_d         = ts_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (run) begin
            ts_d = ts_q + TS_W'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_ovf) begin
                drop_count_d = DROP_W'(1);
            end else if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + DROP_W'(1);
            end
        end else if (clear_ovf) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q         <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            ts_q         <= ts_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

endmodule

// File: tb/tb_rm_m8c7_report_collector.sv
// Directed scenarios plus a randomized phase, all checked every cycle against a queue-based model.
module tb_rm_m8c7_report_collector;
    import rm_m8c7_pkg::*;

    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;

    logic                clk;
    logic                reset;
    logic                run;
    logic [REPORT_W-1:0] reports;
    logic                clear_ovf;
    logic [4:0]          level;
    logic                overflow;
    logic [DROP_W-1:0]   drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    rm_m8c7_report_collector_if bus ();

    rm_m8c7_report_collector #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .reports    (reports),
        .clear_ovf  (clear_ovf),
        .out_if     (bus.master),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a queue of records plus plain counters.
    logic [TS_W+REPORT_W-1:0] mq[$];
    logic [TS_W-1:0]          m_ts;
    logic                     m_ovf;
    int                       m_drop;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_ts   = '0;
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            bit m_pop, m_full, m_cap, m_drop_now;
            m_pop      = (mq.size() > 0) && bus.out_ready;
            m_full     = (mq.size() == DEPTH);
            m_cap      = run && (reports != '0);
            m_drop_now = m_cap && m_full && !m_pop;
            if (m_pop) void'(mq.pop_front());
            if (m_cap && (!m_full || m_pop)) mq.push_back({m_ts, reports});
            if (m_drop_now) begin
                m_ovf  = 1'b1;
                m_drop = clear_ovf ? 1 : ((m_drop == 65535) ? 65535 : m_drop + 1);
            end else if (clear_ovf) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
            if (run) m_ts = m_ts + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [TS_W+REPORT_W-1:0] act,
                               input logic [TS_W+REPORT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            checkOutput("model_out_valid", bus.out_valid, mq.size() > 0);
            checkOutput("model_level", level, mq.size());
            checkOutput("model_overflow", overflow, m_ovf);
            checkOutput("model_drop_count", drop_count, m_drop);
            if (mq.size() > 0) checkOutput("model_out_data", bus.out_data, mq[0]);
        end
    end

    task automatic applyStimulus(input logic r, input logic [REPORT_W-1:0] rep,
                                 input logic rdy, input logic clr);
        run           = r;
        reports       = rep;
        bus.out_ready = rdy;
        clear_ovf     = clr;
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] rnd;
        reset         = 1'b0;
        run           = 1'b0;
        reports       = '0;
        clear_ovf     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_out_data", bus.out_data, 0);
        checkOutput("reset_level", level, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_drop_count", drop_count, 0);
        reset = 1'b1;

        repeat (10) applyStimulus(1'b1, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 36'h20, 1'b0, 1'b0);
        checkOutput("first_valid", bus.out_valid, 1);
        checkOutput("first_record", bus.out_data, {32'd10, 36'h20});
        checkOutput("first_level", level, 1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // ts is 11 here; 16 of these 20 captures fit, 4 are dropped.
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, REPORT_W'(i + 1), 1'b0, 1'b0);
        checkOutput("burst_level", level, 16);
        checkOutput("burst_overflow", overflow, 1);
        checkOutput("burst_drop_count", drop_count, 4);
        checkOutput("burst_head_ts", bus.out_data.ts, 32'd11);

        applyStimulus(1'b1, 36'h1, 1'b1, 1'b0);
        checkOutput("full_pushpop_level", level, 16);
        checkOutput("full_pushpop_drops", drop_count, 4);
        checkOutput("full_pushpop_head", bus.out_data, {32'd12, 36'h2});

        applyStimulus(1'b1, 36'h2, 1'b0, 1'b1);
        checkOutput("drop_clear_overflow", overflow, 1);
        checkOutput("drop_clear_count", drop_count, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("clear_overflow", overflow, 0);
        checkOutput("clear_count", drop_count, 0);

        repeat (17) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("drained_level", level, 0);

        // ts is 33: run toggling must yield exactly timestamps 33 and 34.
        applyStimulus(1'b1, '1, 1'b0, 1'b0);
        applyStimulus(1'b0, '1, 1'b0, 1'b0);
        applyStimulus(1'b1, '1, 1'b0, 1'b0);
        checkOutput("toggle_level", level, 2);
        checkOutput("toggle_head0", bus.out_data, {32'd33, 36'hF_FFFF_FFFF});
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("toggle_head1", bus.out_data, {32'd34, 36'hF_FFFF_FFFF});

        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom, $urandom};
            applyStimulus($urandom_range(0, 4) != 0,
                          ($urandom_range(0, 2) == 0) ? '0 : rnd[REPORT_W-1:0],
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 19) == 0);
        end

        repeat (20) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, REPORT_W'(36'h100 << i), 1'b0, 1'b0);
        checkOutput("prereset_level", level, 7);
        #2;
        reset = 1'b0;
        run   = 1'b0;
        #1;
        checkOutput("async_reset_valid", bus.out_valid, 0);
        checkOutput("async_reset_level", level, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 36'h8, 1'b0, 1'b0);
        checkOutput("post_reset_record", bus.out_data, {32'd0, 36'h8});
        checkOutput("post_reset_level", level, 1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rm_m8c7_report_collector.md
# rm_m8c7_report_collector

Downstream neighbour of the monitor-8 cluster-7 stage-0 automata block. Each `run` cycle it samples the 36 report wires that the nine `ltl*c7` automata produce. It timestamps every cycle in which at least one report fires and buffers the resulting record in a FIFO. The host-side readout drains the FIFO over a valid/ready interface. Overflow is detected, counted and flagged; it never stalls the automata.

## Interface
- `REPORT_W`, 36: report vector width, in stage-0 port order (ltl8 bits 3:0 … ltl4 bits 35:32).
- `TS_W`, 32: timestamp counter width.
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥2.
- `DROP_W`, 16: dropped-record counter width.

Ports:
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
- `run`  in  1  same `run` that drives stage 0; qualifies sampling and the timestamp.
- `reports`  in  REPORT_W  concatenated stage-0 report outputs.
- `clear_ovf`  in  1  synchronous pulse; clears `overflow` and `drop_count`.
- `out_valid`  out  1  head record available.
- `out_ready`  in  1  consumer accepts head record.
- `out_data`  out  TS_W+REPORT_W  `{timestamp, reports}`.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky; a record was dropped.
- `drop_count`  out  DROP_W  saturating count of dropped records.

## Operation
- `ts` counter: increments by 1 on every edge with `run`=1. It wraps modulo 2^TS_W and holds when `run`=0.
- Capture condition: `run`=1 and `|reports`=1.
- Captured record: `{ts, reports}`, where `ts` is its value before this edge's increment.
- Push: capture and (not full or pop this edge).
- Drop: capture and full with no pop.
- Pop: `out_valid`=1 and `out_ready`=1.
- On a drop:
  - `overflow` is set.
  - `drop_count` increments and saturates at 2^DROP_W−1.
  - Nothing is written and the FIFO is unchanged.
- `clear_ovf`:
  - On an edge with no drop, it zeroes `overflow` and `drop_count`.
  - On the same edge as a drop, the drop wins: `overflow`=1 and `drop_count`=1.
- `out_data` is only meaningful while `out_valid`=1. It must hold stable while `out_valid`=1 and `out_ready`=0.
- Reports are not edge-detected: a report held high for N `run` cycles yields N records.
- FIFO state is a two-state machine, EMPTY/NONEMPTY:
  - EMPTY→NONEMPTY on push.
  - NONEMPTY→EMPTY on a pop with no push when `level`=1.
- Full is `level`=DEPTH. Read/write pointers are $clog2(DEPTH)+1 bits and wrap naturally.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `level`=0, `overflow`=0, `drop_count`=0. Internal `ts`=0.
- Capture-to-`out_valid` latency is 1 cycle. There is no combinational path from `reports` or `run` to any output.
- `level` reflects the push/pop of the preceding edge.
- Simultaneous push and pop:
  - Level is unchanged.
  - When full, the push is accepted with no drop.
  - When `level`=1, `out_valid` stays 1 and the new record appears next cycle.
- Push at empty: there is no bypass; `out_valid` rises the cycle after the push.
- `out_ready` is honoured only when `out_valid`=1. A pop at empty is ignored.
- Reset asserted mid-operation:
  - All state returns to reset values on the same cycle, asynchronously.
  - In-flight records are discarded.
  - Release is synchronised externally; the first edge after release may capture.

## Structure
- The package `rm_m8c7_pkg` holds:
  - `REPORT_W`, `TS_W`.
  - A typedef for the record: `{ts, reports}`.
  - Report bit-index constants per automaton (e.g. `LTL8_BASE`=0 … `LTL4_BASE`=32).
- One sub-module, `rm_sync_fifo`: parameterised width/depth, async active-low reset, registered output, `level`/`full`/`empty`.
- The collector top contains the `ts` counter, capture/drop logic and overflow counters.

## Test plan
- Reset, then `run`=1 with `reports`=0 for 10 cycles. Then pulse bit 5 at ts=10 → one record `{32'd10, 36'h20}`; `out_valid` rises 1 cycle later; `level`=1.
- Hold `out_ready`=0 and inject 20 consecutive captures with DEPTH=16 → `level`=16, `overflow`=1, `drop_count`=4. The head record keeps the first timestamp, stable.
- Full FIFO with `out_ready`=1 and a capture on the same edge → no drop; `level` stays 16; the next head is the second record.
- Drop coinciding with `clear_ovf` → `overflow`=1, `drop_count`=1. A later `clear_ovf` alone → both return to 0.
- `run` toggling 1,0,1 with `reports`=all-ones → records carry timestamps t and t+1 only; no capture while `run`=0.
- Assert `reset` low with `level`=7 mid-burst → `out_valid`=0 and `level`=0 immediately. After release, the next capture carries ts=0.
